// File: rtl/ks_cskip_pipe_if.sv
// rtl/ks_cskip_pipe_if.sv - operand/result handshake bundle for ks_cskip_pipe
interface ks_cskip_pipe_if #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 16,
  parameter int CNT_W = 16
);
  localparam int NBLK = WIDTH / BLOCK;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic [NBLK-1:0]  skip_mask;
  logic [CNT_W-1:0] skip_cnt;
  logic             clr_stats;

  modport master (
    output in_valid, x1, x2, cin, sub, out_ready, clr_stats,
    input  in_ready, out_valid, s, cout, ovf, skip_mask, skip_cnt
  );

  modport slave (
    input  in_valid, x1, x2, cin, sub, out_ready, clr_stats,
    output in_ready, out_valid, s, cout, ovf, skip_mask, skip_cnt
  );
endinterface

// File: rtl/ks_cskip_pipe.sv
// rtl/ks_cskip_pipe.sv - pipelined carry-skip add/sub, one Kogge-Stone block per stage
module ks_cskip_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 16,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  ks_cskip_pipe_if.slave bus
);
  localparam int NBLK = WIDTH / BLOCK;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
    logic [NBLK-1:0]  sk;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  typedef struct packed {
    logic [BLOCK-1:0] sum;
    logic             cgen;
    logic             cm;
    logic             gp;
  } blk_t;

  function automatic blk_t ks_block(input logic [BLOCK-1:0] a, input logic [BLOCK-1:0] b,
                                    input logic c);
    logic [BLOCK-1:0] p, pp, gg, cv;
    blk_t r;
    p  = a ^ b;
    pp = p;
    gg = a & b;
    // In-place prefix: walking j downwards keeps j-d at the previous level
    for (int d = 1; d < BLOCK; d = d * 2) begin
      for (int j = BLOCK - 1; j >= d; j--) begin
        gg[j] = gg[j] | (pp[j] & gg[j-d]);
        pp[j] = pp[j] & pp[j-d];
      end
    end
    cv[0] = c;
    for (int j = 1; j < BLOCK; j++) cv[j] = gg[j-1] | (pp[j-1] & c);
    r.sum  = p ^ cv;
    r.cgen = gg[BLOCK-1] | (pp[BLOCK-1] & c);
    r.cm   = cv[BLOCK-1];
    r.gp   = &p;
    return r;
  endfunction

  function automatic stage_t advance(input stage_t src, input int k);
    blk_t   br;
    stage_t r;
    br = ks_block(src.a[k*BLOCK +: BLOCK], src.b[k*BLOCK +: BLOCK], src.c);
    r = src;
    r.s[k*BLOCK +: BLOCK] = br.sum;
    r.c     = br.gp ? src.c : br.cgen;
    r.cm    = br.cm;
    r.sk[k] = br.gp;
    return r;
  endfunction

  stage_t           r_q [NBLK];
  stage_t           nxt [NBLK];
  stage_t           head;
  stage_t           last;
  logic             en;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   cnt_sum;

  assign last         = r_q[NBLK-1];
  assign en           = !last.v || bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    head   = '0;
    head.v = bus.in_valid;
    head.a = bus.x1;
    head.b = bus.sub ? ~bus.x2 : bus.x2;
    head.c = bus.sub ? ~bus.cin : bus.cin;
    nxt[0] = advance(head, 0);
    for (int k = 1; k < NBLK; k++) nxt[k] = advance(r_q[k-1], k);
  end

  // Single global enable: every stage, bubbles included, moves or holds together
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) r_q[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < NBLK; k++) r_q[k] <= nxt[k];
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < NBLK; k++) pop = pop + (CNT_W+1)'(last.sk[k]);
    cnt_sum = {1'b0, cnt_q} + pop;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr_stats) begin
      cnt_q <= '0;
    end else if (last.v && bus.out_ready) begin
      cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  assign bus.out_valid = last.v;
  assign bus.s         = last.s;
  assign bus.cout      = last.c;
  assign bus.ovf       = last.cm ^ last.c;
  assign bus.skip_mask = last.sk;
  assign bus.skip_cnt  = cnt_q;
endmodule

// File: tb/tb_ks_cskip_pipe.sv
// tb/tb_ks_cskip_pipe.sv - self-checking bench for ks_cskip_pipe (32-bit, two 16-bit blocks)
module tb_ks_cskip_pipe;
  localparam int WIDTH = 32;
  localparam int BLOCK = 16;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic [1:0]  mask;
  } res_t;

  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] x2;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ks_cskip_pipe_if #(.WIDTH(WIDTH), .BLOCK(BLOCK), .CNT_W(CNT_W)) bus ();

  ks_cskip_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  bit          mon_en = 1'b0;
  res_t        q[$];
  res_t        mon_e;
  logic [1:0]  mon_pm;
  logic [16:0] mon_acc;
  logic [15:0] exp_cnt = '0;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic plus the signed-overflow sign rule
  function automatic res_t model(input logic [31:0] x1, input logic [31:0] x2,
                                 input logic cin, input logic sub);
    logic [31:0] b;
    logic        c0;
    logic [32:0] t;
    res_t        r;
    b      = sub ? ~x2 : x2;
    c0     = sub ? ~cin : cin;
    t      = {1'b0, x1} + {1'b0, b} + {32'b0, c0};
    r.s    = t[31:0];
    r.cout = t[32];
    r.ovf  = (x1[31] == b[31]) && (t[31] != x1[31]);
    for (int k = 0; k < 2; k++) r.mask[k] = &(x1[k*16 +: 16] ^ b[k*16 +: 16]);
    return r;
  endfunction

  // Scoreboard and skip-counter model, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      check("skip_cnt", 64'(bus.skip_cnt), 64'(exp_cnt));
      if (rst) begin
        q.delete();
        exp_cnt = '0;
      end else begin
        mon_pm = 2'b00;
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got s=%h expected no transaction", bus.s);
          end else begin
            mon_e = q.pop_front();
            check("s", 64'(bus.s), 64'(mon_e.s));
            check("cout", 64'(bus.cout), 64'(mon_e.cout));
            check("ovf", 64'(bus.ovf), 64'(mon_e.ovf));
            check("skip_mask", 64'(bus.skip_mask), 64'(mon_e.mask));
            mon_pm = mon_e.mask;
            n_out++;
          end
        end
        if (bus.in_valid && bus.in_ready) q.push_back(model(bus.x1, bus.x2, bus.cin, bus.sub));
        if (bus.clr_stats) begin
          exp_cnt = '0;
        end else begin
          mon_acc = {1'b0, exp_cnt} + 17'(mon_pm[0]) + 17'(mon_pm[1]);
          exp_cnt = (mon_acc > 17'h0FFFF) ? 16'hFFFF : mon_acc[15:0];
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sb);
    int t = 0;
    bus.x1 = a; bus.x2 = b; bus.cin = c; bus.sub = sb; bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 200);
    if (!bus.in_ready) check("send_timeout", 64'(t), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    res_t bp_a;
    int   n0;
    int   t;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 2'b11}};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 2'b00}};
    vecs[2] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, '{32'h0000_0002, 1'b1, 1'b0, 2'b10}};
    vecs[3] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 2'b10}};
    vecs[4] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, '{32'h0001_0000, 1'b0, 1'b0, 2'b01}};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 2'b00}};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 2'b11}};
    vecs[7] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 2'b00}};

    bus.in_valid = 1'b0; bus.x1 = '0; bus.x2 = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1; bus.clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_s", 64'(bus.s), 64'(0));
    check("rst_flags", 64'({bus.cout, bus.ovf, bus.skip_mask}), 64'(0));
    check("rst_skip_cnt", 64'(bus.skip_cnt), 64'(0));
    exp_cnt = '0;
    mon_en  = 1'b1;

    // Directed vectors, one at a time, with exact latency
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.x1 = vecs[i].x1; bus.x2 = vecs[i].x2; bus.cin = vecs[i].cin; bus.sub = vecs[i].sub;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("lat_early", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      check("lat_valid", 64'(bus.out_valid), 64'(1));
      check("vec_s", 64'(bus.s), 64'(vecs[i].exp.s));
      check("vec_cout", 64'(bus.cout), 64'(vecs[i].exp.cout));
      check("vec_ovf", 64'(bus.ovf), 64'(vecs[i].exp.ovf));
      check("vec_mask", 64'(bus.skip_mask), 64'(vecs[i].exp.mask));
    end
    @(posedge clk); #1;
    drain();

    // Backpressure: 3-cycle stall after the second of four back-to-back adds
    n0   = n_out;
    bp_a = model(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    bus.x1 = 32'hDEAD_BEEF; bus.x2 = 32'h1234_5678; bus.cin = 1'b0; bus.sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_hold_s", 64'(bus.s), 64'(bp_a.s));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
    send(32'hFFFF_0000, 32'h0001_FFFF, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    drain();
    check("bp_delivered", 64'(n_out - n0), 64'(4));

    // Skip counter: accumulate, clear on a handshake, then saturate
    bus.clr_stats = 1'b1;
    @(posedge clk); #1;
    bus.clr_stats = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("cnt_three", 64'(bus.skip_cnt), 64'(6));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.out_valid && t < 20);
    check("clr_wait_valid", 64'(bus.out_valid), 64'(1));
    @(posedge clk); #1;
    bus.clr_stats = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.clr_stats = 1'b0;
    @(negedge clk);
    check("cnt_clr_prio", 64'(bus.skip_cnt), 64'(0));
    check("clr_consumed", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    bus.x1 = 32'hFFFF_FFFF; bus.x2 = 32'h0; bus.cin = 1'b1; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    repeat (32770) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("cnt_saturate", 64'(bus.skip_cnt), 64'(16'hFFFF));
    @(posedge clk); #1;

    // Reset with two transactions in flight
    bus.out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("mid_rst_s", 64'(bus.s), 64'(0));
    check("mid_rst_flags", 64'({bus.cout, bus.ovf, bus.skip_mask}), 64'(0));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_ghost", 64'(bus.out_valid), 64'(0));
    end
    @(posedge clk); #1;

    // Random sweep with random bubbles, backpressure and stat clears
    for (int i = 0; i < 1500; i++) begin
      int mode;
      bus.in_valid = ($urandom % 4) != 0;
      bus.x1 = $urandom;
      mode = $urandom % 4;
      bus.x2 = (mode == 0) ? ~bus.x1 : (mode == 1) ? bus.x1 : $urandom;
      bus.cin = $urandom % 2;
      bus.sub = $urandom % 2;
      bus.out_ready = ($urandom % 4) != 0;
      bus.clr_stats = ($urandom % 64) == 0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.clr_stats = 1'b0;
    drain();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ks_cskip_pipe.md
# ks_cskip_pipe

Parametrised, pipelined carry-skip adder/subtractor built from Kogge-Stone sub-blocks. It generalises the fixed two-block, 32-bit carry-skip adder: operand width and block size are parameters, with one pipeline register stage per block. Valid/ready handshakes sit on both sides, and a subtract mode is added. It also exports per-transaction skip-path indicators and a saturating skip counter, which PPA characterisation runs use to measure how often the bypass path is taken.

## Interface
Parameters:
- WIDTH, 32: operand/sum width; must be a multiple of BLOCK.
- BLOCK, 16: bits per Kogge-Stone sub-block; NBLK = WIDTH/BLOCK, NBLK >= 1.
- CNT_W, 16: width of skip_cnt.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  stage can accept.
- x1  in  WIDTH  operand A.
- x2  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry-out (add) / no-borrow (sub).
- ovf  out  1  signed overflow.
- skip_mask  out  NBLK  bit k = 1 if block k carry took the skip path.
- skip_cnt  out  CNT_W  saturating total of skipped blocks.
- clr_stats  in  1  synchronous clear of skip_cnt.

## Operation
- Effective operands: a = x1; b = sub ? ~x2 : x2; c0 = sub ? ~cin : cin.
  - Add computes x1 + x2 + cin.
  - Sub computes x1 - x2 - cin.
- Per block k:
  - p_k = a[k] ^ b[k], taken over the block's bits.
  - group_p_k = AND of all p_k bits.
  - Block sum and ripple/KS carry c_gen_k are formed from carry-in c_k.
  - c_(k+1) = group_p_k ? c_k : c_gen_k.
  - skip_mask[k] = group_p_k.
- Pipeline registers R1..R_NBLK. Each R_i holds:
  - valid bit;
  - completed sum bits for blocks 0..i-1;
  - carry c_i;
  - skip bits 0..i-1;
  - remaining upper operand bits of a and b;
  - the MSB information needed for ovf.
- Data flow through the pipeline:
  - Block 0 is evaluated combinationally from the inputs and captured into R1.
  - Block i is evaluated from R_i and captured into R_(i+1).
  - Outputs are driven directly from R_NBLK.
- Results:
  - cout = c_NBLK.
  - ovf = carry into MSB XOR carry out of MSB.
  - All results are bit-exact with (a + b + c0) mod 2^(WIDTH+1).
- Flow control:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - When en = 0, all stages hold.
  - Bubbles are not compressed.
- Skip counter:
  - On each output handshake (out_valid && out_ready), skip_cnt += popcount(skip_mask), saturating at 2^CNT_W - 1.
  - clr_stats has priority over the increment: skip_cnt <= 0 that cycle.

## Timing
- Reset (rst = 1 at an edge):
  - All valid bits = 0, so out_valid = 0.
  - s = 0, cout = 0, ovf = 0, skip_mask = 0, skip_cnt = 0.
  - in_ready = 1 on the cycle after reset.
  - Reset mid-operation discards all in-flight transactions; none are output.
- Latency:
  - A transaction accepted at edge E is visible on the outputs after edge E + NBLK - 1, provided no stall occurs.
  - With NBLK = 2, out_valid is high two cycles after the in_valid cycle.
- Throughput: one transaction per cycle while out_ready = 1.
- Backpressure:
  - With out_valid = 1 and out_ready = 0, outputs remain stable and in_ready = 0.
  - No transaction is lost or duplicated.
- in_valid = 0 while en = 1 inserts a bubble that propagates as valid = 0.
- Outputs are fully registered; in_ready is combinational from out_valid and out_ready.

## Test plan
All scenarios use WIDTH = 32, BLOCK = 16.
- Full skip: x1 = 0xFFFFFFFF, x2 = 0, cin = 1, sub = 0 -> s = 0x00000000, cout = 1, ovf = 0, skip_mask = 2'b11, out_valid two cycles after input.
- Signed overflow: x1 = 0x7FFFFFFF, x2 = 1, cin = 0 -> s = 0x80000000, cout = 0, ovf = 1, skip_mask = 2'b00.
- Subtract: x1 = 5, x2 = 3, cin = 0, sub = 1 -> s = 2, cout = 1. Then x1 = 3, x2 = 5, sub = 1 -> s = 0xFFFFFFFE, cout = 0.
- Backpressure: stream 4 back-to-back adds with out_ready low for 3 cycles mid-stream -> in_ready = 0 during the stall, outputs held, all 4 results delivered in order with no loss or duplication.
- Skip counter:
  - 3 full-skip transactions -> skip_cnt = 6.
  - clr_stats pulsed in the same cycle as a 4th handshake -> skip_cnt = 0.
  - Preload near saturation via repeated full-skip transactions -> skip_cnt saturates at 0xFFFF.
- Reset mid-stream: assert rst with 2 transactions in flight -> out_valid = 0 on the next cycle, and neither result ever appears.
- Randomised sweep: random x1, x2, cin and sub -> outputs match the arithmetic model exactly.
